// File: rtl/program_store.sv
// program_store: instruction-side responder for the 8-bit microprocessor.
// Holds a 2^ADDR_W x DATA_W program RAM. It is zeroed after reset and can be
// filled at run time through a valid/ready byte port. The processor is held
// in reset while the RAM is being cleared or loaded.
module program_store #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              oscillator,
   input  logic              reset,
   input  logic [ADDR_W-1:0] instruction_address,
   output logic [DATA_W-1:0] instruction,
   input  logic              load_mode,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic [ADDR_W:0]   load_count,
   output logic [DATA_W-1:0] checksum,
   output logic              overflow,
   output logic              cpu_hold
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W:0]     r_clr_ptr;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W:0]     r_load_count;
   logic [DATA_W-1:0]   r_checksum;
   logic                r_overflow;
   logic [DATA_W-1:0]   r_instruction;
   logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

   logic                w_full;
   logic                w_load_ready;
   logic                w_accept;
   logic                w_overflow_evt;
   logic                w_enter_load;
   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_wdata;

   // load_count can never exceed the depth, so its MSB alone marks "full"
   assign w_full         = r_load_count[ADDR_W];
   assign w_load_ready   = (r_state == ST_LOAD) && load_mode && !w_full;
   assign w_accept       = w_load_ready && load_valid;
   assign w_overflow_evt = (r_state == ST_LOAD) && load_mode && w_full && load_valid;
   assign w_enter_load   = (r_state != ST_LOAD) && (w_next_state == ST_LOAD);

   // State register
   always_ff @(posedge oscillator) begin
      if (reset) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; CLEAR looks at load_mode only on its final write
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_CLEAR: begin
            if (r_clr_ptr[ADDR_W-1:0] == PTR_MAX) begin
               w_next_state = load_mode ? ST_LOAD : ST_RUN;
            end else begin
               w_next_state = ST_CLEAR;
            end
         end
         ST_LOAD: begin
            if (!load_mode) begin
               w_next_state = ST_RUN;
            end else begin
               w_next_state = ST_LOAD;
            end
         end
         ST_RUN: begin
            if (load_mode) begin
               w_next_state = ST_LOAD;
            end else begin
               w_next_state = ST_RUN;
            end
         end
         default: w_next_state = ST_CLEAR;
      endcase
   end

   // Clear pointer walks the whole RAM once per CLEAR pass
   always_ff @(posedge oscillator) begin
      if (reset) begin
         r_clr_ptr <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_clr_ptr <= r_clr_ptr + CNT_ONE;
      end else begin
         r_clr_ptr <= '0;
      end
   end

   // Load bookkeeping: restart on LOAD entry, advance on each handshake
   always_ff @(posedge oscillator) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_load_count <= '0;
         r_checksum   <= '0;
         r_overflow   <= 1'b0;
      end else if (w_enter_load) begin
         r_wr_ptr     <= '0;
         r_load_count <= '0;
         r_checksum   <= '0;
         r_overflow   <= 1'b0;
      end else if (w_accept) begin
         r_wr_ptr     <= r_wr_ptr + PTR_ONE;
         r_load_count <= r_load_count + CNT_ONE;
         r_checksum   <= r_checksum + load_data;
      end else if (w_overflow_evt) begin
         r_overflow   <= 1'b1;
      end else begin
         r_overflow   <= r_overflow;
      end
   end

   // RAM write-port mux: zero fill in CLEAR, handshaked bytes in LOAD
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = r_wr_ptr;
      w_mem_wdata = load_data;
      if (reset) begin
         w_mem_we = 1'b0;
      end else if (r_state == ST_CLEAR) begin
         w_mem_we    = 1'b1;
         w_mem_addr  = r_clr_ptr[ADDR_W-1:0];
         w_mem_wdata = '0;
      end else if (w_accept) begin
         w_mem_we = 1'b1;
      end else begin
         w_mem_we = 1'b0;
      end
   end

   // Program RAM write port
   always_ff @(posedge oscillator) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   // Instruction fetch: one-cycle read in RUN, forced to zero otherwise
   always_ff @(posedge oscillator) begin
      if (reset) begin
         r_instruction <= '0;
      end else if (r_state == ST_RUN) begin
         r_instruction <= r_mem[instruction_address];
      end else begin
         r_instruction <= '0;
      end
   end

   assign instruction = r_instruction;
   assign load_ready  = w_load_ready;
   assign load_count  = r_load_count;
   assign checksum    = r_checksum;
   assign overflow    = r_overflow;
   assign cpu_hold    = (r_state != ST_RUN);

endmodule

// File: tb/tb_program_store.sv
// Directed self-checking bench for program_store.
module tb_program_store;

   logic       oscillator;
   logic       reset;
   logic [7:0] instruction_address;
   logic [7:0] instruction;
   logic       load_mode;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic [8:0] load_count;
   logic [7:0] checksum;
   logic       overflow;
   logic       cpu_hold;

   int checks;
   int failures;

   program_store #(.ADDR_W(8), .DATA_W(8)) dut (
      .oscillator          (oscillator),
      .reset               (reset),
      .instruction_address (instruction_address),
      .instruction         (instruction),
      .load_mode           (load_mode),
      .load_valid          (load_valid),
      .load_data           (load_data),
      .load_ready          (load_ready),
      .load_count          (load_count),
      .checksum            (checksum),
      .overflow            (overflow),
      .cpu_hold            (cpu_hold)
   );

   initial oscillator = 1'b0;
   always #5 oscillator = ~oscillator;

   task automatic tick();
      @(posedge oscillator);
      #1;
   endtask

   // Count cycles until the processor is released (bounded)
   task automatic wait_run(output int n);
      n = 0;
      while (cpu_hold && n < 400) begin
         tick();
         n++;
      end
   endtask

   // Read one RAM byte through the RUN fetch path
   task automatic read_addr(input logic [7:0] a, output logic [7:0] d);
      instruction_address = a;
      tick();
      d = instruction;
   endtask

   // Enter LOAD from RUN, push bytes with valid every cycle, stay in LOAD
   task automatic load_bytes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int n);
      logic [7:0] arr [3];
      arr[0] = b0; arr[1] = b1; arr[2] = b2;
      load_mode = 1'b1;
      tick();
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data  = arr[i];
         tick();
      end
      load_valid = 1'b0;
   endtask

   task automatic leave_load();
      load_mode  = 1'b0;
      load_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      int n;
      logic [7:0] d;
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (instruction !== 8'h00 || load_ready !== 1'b0 || load_count !== 9'd0 ||
          checksum !== 8'h00 || overflow !== 1'b0 || cpu_hold !== 1'b1) begin
         failures++;
         $display("FAIL reset_values: instr=%h ready=%b cnt=%0d cs=%h ov=%b hold=%b required 00 0 0 00 0 1",
                  instruction, load_ready, load_count, checksum, overflow, cpu_hold);
      end
      reset = 1'b0;
      wait_run(n);
      checks++;
      if (n !== 256) begin
         failures++;
         $display("FAIL clear_cycles: got %0d required 256", n);
      end
      read_addr(8'h05, d);
      checks++;
      if (d !== 8'h00) begin
         failures++;
         $display("FAIL run_read_after_clear: got %h required 00", d);
      end
   endtask

   task automatic test_basic_load();
      logic [7:0] d;
      load_bytes(8'h03, 8'hC1, 8'h45, 3);
      checks++;
      if (cpu_hold !== 1'b1) begin
         failures++;
         $display("FAIL hold_in_load: got %b required 1", cpu_hold);
      end
      leave_load();
      checks++;
      if (load_count !== 9'd3 || checksum !== 8'h09) begin
         failures++;
         $display("FAIL basic_counts: cnt=%0d cs=%h required 3 09", load_count, checksum);
      end
      checks++;
      if (cpu_hold !== 1'b0) begin
         failures++;
         $display("FAIL hold_in_run: got %b required 0", cpu_hold);
      end
      read_addr(8'h01, d);
      checks++;
      if (d !== 8'hC1) begin
         failures++;
         $display("FAIL basic_read1: got %h required C1", d);
      end
      read_addr(8'h02, d);
      checks++;
      if (d !== 8'h45) begin
         failures++;
         $display("FAIL basic_read2: got %h required 45", d);
      end
   endtask

   task automatic test_toggle_valid();
      logic [7:0] d;
      load_mode = 1'b1;
      tick();
      load_valid = 1'b1; load_data = 8'h80; tick();
      load_valid = 1'b0; load_data = 8'hAA; tick();
      load_valid = 1'b1; load_data = 8'h90; tick();
      load_valid = 1'b0; load_data = 8'hBB; tick();
      leave_load();
      checks++;
      if (load_count !== 9'd2 || checksum !== 8'h10) begin
         failures++;
         $display("FAIL toggle_counts: cnt=%0d cs=%h required 2 10", load_count, checksum);
      end
      read_addr(8'h00, d);
      checks++;
      if (d !== 8'h80) begin
         failures++;
         $display("FAIL toggle_read0: got %h required 80", d);
      end
      read_addr(8'h01, d);
      checks++;
      if (d !== 8'h90) begin
         failures++;
         $display("FAIL toggle_read1: got %h required 90", d);
      end
      read_addr(8'h02, d);
      checks++;
      if (d !== 8'h45) begin
         failures++;
         $display("FAIL toggle_old_tail: got %h required 45", d);
      end
   endtask

   task automatic test_full_overflow();
      logic [7:0] d;
      load_mode = 1'b1;
      tick();
      for (int i = 0; i < 256; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h01;
         tick();
      end
      checks++;
      if (load_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_ready: got %b required 0", load_ready);
      end
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL overflow_early: got %b required 0", overflow);
      end
      load_valid = 1'b1;
      load_data  = 8'h55;
      tick();
      checks++;
      if (overflow !== 1'b1 || load_count !== 9'd256 || checksum !== 8'h00) begin
         failures++;
         $display("FAIL full_state: ov=%b cnt=%0d cs=%h required 1 256 00",
                  overflow, load_count, checksum);
      end
      leave_load();
      read_addr(8'h00, d);
      checks++;
      if (d !== 8'h01) begin
         failures++;
         $display("FAIL full_read0: got %h required 01", d);
      end
      read_addr(8'hFF, d);
      checks++;
      if (d !== 8'h01) begin
         failures++;
         $display("FAIL full_read255: got %h required 01", d);
      end
      checks++;
      if (overflow !== 1'b1) begin
         failures++;
         $display("FAIL overflow_sticky: got %b required 1", overflow);
      end
   endtask

   task automatic test_partial_reload();
      logic [7:0] d;
      load_bytes(8'h11, 8'h22, 8'h00, 2);
      leave_load();
      instruction_address = 8'h01;
      load_bytes(8'h7F, 8'h00, 8'h00, 1);
      checks++;
      if (instruction !== 8'h00) begin
         failures++;
         $display("FAIL instr_forced_in_load: got %h required 00", instruction);
      end
      leave_load();
      checks++;
      if (load_count !== 9'd1 || checksum !== 8'h7F || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reload_counts: cnt=%0d cs=%h ov=%b required 1 7F 0",
                  load_count, checksum, overflow);
      end
      read_addr(8'h00, d);
      checks++;
      if (d !== 8'h7F) begin
         failures++;
         $display("FAIL reload_read0: got %h required 7F", d);
      end
      read_addr(8'h01, d);
      checks++;
      if (d !== 8'h22) begin
         failures++;
         $display("FAIL reload_read1: got %h required 22", d);
      end
   endtask

   task automatic test_reset_mid_load();
      int n;
      int bad;
      logic [7:0] d;
      load_bytes(8'hA5, 8'h5A, 8'h00, 2);
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      load_mode = 1'b0;
      checks++;
      if (load_count !== 9'd0 || checksum !== 8'h00 || cpu_hold !== 1'b1) begin
         failures++;
         $display("FAIL midreset_state: cnt=%0d cs=%h hold=%b required 0 00 1",
                  load_count, checksum, cpu_hold);
      end
      wait_run(n);
      checks++;
      if (n !== 256) begin
         failures++;
         $display("FAIL midreset_clear_cycles: got %0d required 256", n);
      end
      bad = 0;
      for (int a = 0; a < 256; a++) begin
         read_addr(a[7:0], d);
         if (d !== 8'h00) begin
            bad++;
         end
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL midreset_ram_zero: nonzero_addrs=%0d required 0", bad);
      end
   endtask

   initial begin
      checks              = 0;
      failures            = 0;
      reset               = 1'b1;
      instruction_address = 8'h00;
      load_mode           = 1'b0;
      load_valid          = 1'b0;
      load_data           = 8'h00;
      test_reset();
      test_basic_load();
      test_toggle_valid();
      test_full_overflow();
      test_partial_reload();
      test_reset_mid_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
